// File: rtl/mem_stage_dh.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_dh
//  Description : Memory-access stage for a split request/response data bus.
//                Holds loads until data_ok, buffers responses while WB stalls,
//                extracts sub-word/lwl/lwr data and drops flushed responses.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_dh #(
    parameter int MAX_DISCARD = 2,
    parameter int ES_BUS_WD   = 76,
    parameter int MS_BUS_WD   = 75,
    parameter int FWD_BUS_WD  = 42
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_allowin,
    output logic                  ms_allowin,
    input  logic                  es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0]  es_to_ms_bus,
    input  logic                  es_cancel_pending,
    output logic                  ms_to_ws_valid,
    output logic [MS_BUS_WD-1:0]  ms_to_ws_bus,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    output logic [FWD_BUS_WD-1:0] ms_fwd_blk_bus,
    output logic                  ms_ex_o,
    output logic                  ms_inst_mfc0_o,
    input  logic                  ws_ex,
    input  logic                  eret_flush
);

    localparam int c_CNT_W = $clog2(MAX_DISCARD + 1);
    localparam logic [c_CNT_W+1:0] c_CNT_MAX_W = (c_CNT_W+2)'(MAX_DISCARD);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(MAX_DISCARD);

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LB   = 3'd1;
    localparam logic [2:0] c_LD_LBU  = 3'd2;
    localparam logic [2:0] c_LD_LH   = 3'd3;
    localparam logic [2:0] c_LD_LHU  = 3'd4;
    localparam logic [2:0] c_LD_LW   = 3'd5;
    localparam logic [2:0] c_LD_LWL  = 3'd6;
    localparam logic [2:0] c_LD_LWR  = 3'd7;

    logic                 r_ms_valid;
    logic [ES_BUS_WD-1:0] r_es_bus;
    logic                 r_buf_valid;
    logic [31:0]          r_rdata_buf;
    logic [c_CNT_W-1:0]   r_discard_cnt;

    logic        w_ex;
    logic        w_mfc0;
    logic        w_req;
    logic [2:0]  w_ld_op;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_exe_result;
    logic [31:0] w_pc;

    assign w_ex         = r_es_bus[75];
    assign w_mfc0       = r_es_bus[74];
    assign w_req        = r_es_bus[73];
    assign w_ld_op      = r_es_bus[72:70];
    assign w_gr_we      = r_es_bus[69];
    assign w_dest       = r_es_bus[68:64];
    assign w_exe_result = r_es_bus[63:32];
    assign w_pc         = r_es_bus[31:0];

    logic w_flush;
    logic w_data_hit;
    logic w_ready_go;
    logic w_leave;
    logic w_capture;
    logic w_owed;

    assign w_flush    = ws_ex | eret_flush;
    assign w_data_hit = data_sram_data_ok & (r_discard_cnt == '0);
    assign w_ready_go = !w_req | r_buf_valid | w_data_hit;
    assign w_leave    = r_ms_valid & w_ready_go & ws_allowin;
    assign ms_allowin = !r_ms_valid | (w_ready_go & ws_allowin);

    // A response arriving while WB stalls must be parked: the bus won't repeat it.
    assign w_capture  = w_data_hit & r_ms_valid & w_req & !r_buf_valid & !ws_allowin;
    assign w_owed     = w_flush & r_ms_valid & w_req & !r_buf_valid & !w_data_hit;

    logic [1:0]         w_cnt_inc;
    logic               w_cnt_dec;
    logic [c_CNT_W+1:0] w_cnt_sum;
    logic [c_CNT_W-1:0] w_cnt_next;

    assign w_cnt_inc  = {1'b0, w_owed} + {1'b0, es_cancel_pending};
    assign w_cnt_dec  = data_sram_data_ok & (r_discard_cnt != '0);
    assign w_cnt_sum  = {2'b00, r_discard_cnt} + {{c_CNT_W{1'b0}}, w_cnt_inc}
                      - {{(c_CNT_W+1){1'b0}}, w_cnt_dec};
    assign w_cnt_next = (w_cnt_sum > c_CNT_MAX_W) ? c_CNT_MAX : w_cnt_sum[c_CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid    <= 1'b0;
            r_es_bus      <= '0;
            r_buf_valid   <= 1'b0;
            r_rdata_buf   <= '0;
            r_discard_cnt <= '0;
        end else begin
            if (w_flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                r_es_bus <= es_to_ms_bus;
            end
            if (w_flush || w_leave) begin
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_buf_valid <= 1'b1;
            end
            if (w_capture) begin
                r_rdata_buf <= data_sram_rdata;
            end
            r_discard_cnt <= w_cnt_next;
`ifndef SYNTHESIS
            assert (w_cnt_sum <= c_CNT_MAX_W);
`endif
        end
    end

    logic [31:0] w_ld_word;
    logic [1:0]  w_addr;
    logic [31:0] w_rsh;
    logic [31:0] w_lsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_ld_word = r_buf_valid ? r_rdata_buf : data_sram_rdata;
    assign w_addr    = w_exe_result[1:0];
    assign w_rsh     = w_ld_word >> {w_addr, 3'b000};
    // 8*(3-a) equals 8*(~a) for a two-bit offset.
    assign w_lsh     = w_ld_word << {~w_addr, 3'b000};
    assign w_byte    = w_rsh[7:0];
    assign w_half    = w_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    logic [31:0] w_load_data;
    logic [3:0]  w_gr_strb;

    always_comb begin
        w_load_data = w_ld_word;
        w_gr_strb   = {4{w_gr_we}};
        case (w_ld_op)
            c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_data = {24'd0, w_byte};
            c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_load_data = {16'd0, w_half};
            c_LD_LW:  w_load_data = w_ld_word;
            c_LD_LWL: begin
                w_load_data = w_lsh;
                case (w_addr)
                    2'd0:    w_gr_strb = 4'b1000;
                    2'd1:    w_gr_strb = 4'b1100;
                    2'd2:    w_gr_strb = 4'b1110;
                    default: w_gr_strb = 4'b1111;
                endcase
            end
            c_LD_LWR: begin
                w_load_data = w_rsh;
                case (w_addr)
                    2'd0:    w_gr_strb = 4'b1111;
                    2'd1:    w_gr_strb = 4'b0111;
                    2'd2:    w_gr_strb = 4'b0011;
                    default: w_gr_strb = 4'b0001;
                endcase
            end
            default: w_load_data = w_ld_word;
        endcase
    end

    logic [31:0] w_final_result;
    logic        w_is_load;
    logic        w_blk;
    logic [3:0]  w_fwd_valid;

    assign w_is_load      = (w_ld_op != c_LD_NONE);
    assign w_final_result = w_is_load ? w_load_data : w_exe_result;

    assign ms_to_ws_valid = r_ms_valid & w_ready_go & !w_flush;
    assign ms_to_ws_bus   = {w_ex, w_mfc0, w_gr_strb, w_dest, w_final_result, w_pc};

    assign w_fwd_valid    = {4{r_ms_valid & w_ready_go}} & w_gr_strb;
    assign w_blk          = (r_ms_valid & w_gr_we & w_is_load & !w_ready_go)
                          | (r_ms_valid & w_mfc0);
    assign ms_fwd_blk_bus = {w_blk, w_fwd_valid, w_dest, w_final_result};

    assign ms_ex_o        = r_ms_valid & w_ex;
    assign ms_inst_mfc0_o = r_ms_valid & w_mfc0;

endmodule
`default_nettype wire
